sm_stream_accumulator: RTL and testbench

Sequential sign-magnitude accumulator: consumes a valid/ready stream of W-bit sign-magnitude operands, each tagged add or subtract, and produces one saturated sign-magnitude result per packet (terminated by `in_last`). It sits downstream of the matrix datapath in the Kalman filter core. It reduces row/column partial terms (e.g. P·Hᵀ accumulation) using the same per-step arithmetic as the combinational `adder_subs`, so a chained sequence of `adder_subs` evaluations is bit-exact to one packet through this block.

---
 rtl/sm_stream_accumulator.sv | 126 ++++++++++++
 tb/tb_sm_stream_accumulator.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_stream_accumulator.sv
// Sequential sign-magnitude accumulator.
// Consumes a valid/ready stream of sign-magnitude operands, each tagged add or
// subtract, and emits one saturated sign-magnitude result per packet. Every step
// uses the same arithmetic as one adder_subs evaluation, so a packet through this
// block matches a chain of adder_subs evaluations bit for bit.
//
// Handshake: an operand moves on a rising edge with in_valid && in_ready, and a
// result moves on a rising edge with out_valid && out_ready. Once valid is raised
// it is held with its data until the transfer. in_ready and out_valid are
// registered and do not depend combinationally on the other side's handshake.
module sm_stream_accumulator #(
    parameter int W     = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_op_add,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Largest magnitude, widened to the W+1-bit two's-complement working width.
    localparam logic [W:0]       MAG_MAX = {2'b00, {(W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]   state;
    logic [W-1:0] acc;
    logic         sat;
    logic [CNT_W-1:0] count;

    logic         xfer_in;
    logic         xfer_out;
    logic [W:0]   acc_mag;
    logic [W:0]   in_mag;
    logic [W:0]   acc_tc;
    logic [W:0]   in_tc;
    logic [W:0]   sum_tc;
    logic [W:0]   sum_abs;
    logic         step_sat;
    logic [W-2:0] res_mag;
    logic         res_sign;
    logic [W-1:0] step_res;

    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = out_valid && out_ready;
    assign out_data  = acc;
    assign out_sat   = sat;
    assign out_count = count;
    assign dbg_state = state;

    // One accumulate step: sign-magnitude -> two's complement, add/sub, then back
    // to sign-magnitude with the magnitude clamped; a zero result is always +0.
    always_comb begin
        acc_mag  = {2'b00, acc[W-2:0]};
        in_mag   = {2'b00, in_data[W-2:0]};
        acc_tc   = acc[W-1] ? (~acc_mag + 1'b1) : acc_mag;
        in_tc    = in_data[W-1] ? (~in_mag + 1'b1) : in_mag;
        sum_tc   = in_op_add ? (acc_tc + in_tc) : (acc_tc - in_tc);
        sum_abs  = sum_tc[W] ? (~sum_tc + 1'b1) : sum_tc;
        step_sat = (sum_abs > MAG_MAX);
        res_mag  = step_sat ? {(W-1){1'b1}} : sum_abs[W-2:0];
        res_sign = sum_tc[W] && (sum_abs != '0);
        step_res = {res_sign, res_mag};
    end

    // Packet FSM with the accumulator, sticky saturation flag and term counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            sat       <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACC: begin
                    if (xfer_in) begin
                        acc   <= step_res;
                        sat   <= sat | step_sat;
                        count <= (count == CNT_MAX) ? count : count + 1'b1;
                        if (in_last) begin
                            state     <= S_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                S_DONE: begin
                    // Clearing here means the next packet starts from +0.
                    if (xfer_out) begin
                        state     <= S_IDLE;
                        acc       <= '0;
                        sat       <= 1'b0;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    acc       <= '0;
                    sat       <= 1'b0;
                    count     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_stream_accumulator.sv
// Bench for sm_stream_accumulator: directed scenarios plus a randomized
// regression against a signed-integer model of chained saturating add/sub.
module tb_sm_stream_accumulator;

    localparam int W     = 24;
    localparam int CNT_W = 8;
    localparam int MAXV  = (1 << (W - 1)) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_op_add;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;
    logic [1:0]       dbg_state;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]     exp_q[$];
    logic             exp_sat_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];

    sm_stream_accumulator #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op_add (in_op_add),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model helpers ----------------
    function automatic int sm_to_int(input logic [W-1:0] x);
        int m;
        m = int'(x[W-2:0]);
        return x[W-1] ? -m : m;
    endfunction

    function automatic logic [W-1:0] int_to_sm(input int v);
        logic [W-1:0] r;
        if (v < 0) r = {1'b1, 23'(-v)};
        else       r = {1'b0, 23'(v)};
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Offers one operand and holds it until accepted (bounded wait).
    task automatic send_term(input logic [W-1:0] d, input logic add, input logic last, output bit ok);
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_op_add = add;
        in_last   = last;
        for (int i = 0; i < 100; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Waits for a result, stalls it for 'delay' cycles, captures it, then accepts it.
    task automatic get_result(input int delay, output logic [W-1:0] d, output logic s,
                              output logic [CNT_W-1:0] c, output bit ok);
        ok        = 1'b0;
        out_ready = 1'b0;
        d = '0; s = 1'b0; c = '0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            for (int i = 0; i < delay; i++) begin
                @(posedge clk); #1;
            end
            d = out_data;
            s = out_sat;
            c = out_count;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== '0)    begin bad++; $display("FAIL reset_out_data: got %h want 000000", out_data); end
        total++; if (out_sat !== 1'b0)   begin bad++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        total++; if (out_count !== '0)   begin bad++; $display("FAIL reset_out_count: got %0d want 0", out_count); end

        // Asynchronous reset mid-packet: cleared before any clock edge.
        send_term(24'h000100, 1'b1, 1'b0, ok);
        send_term(24'h000020, 1'b1, 1'b0, ok);
        #3 rst = 1'b1;
        #1;
        total++; if (out_data !== '0)    begin bad++; $display("FAIL midpkt_rst_data: got %h want 000000", out_data); end
        total++; if (out_count !== '0)   begin bad++; $display("FAIL midpkt_rst_count: got %0d want 0", out_count); end
        @(posedge clk); #1 rst = 1'b0;

        // Asynchronous reset in DONE: result discarded.
        send_term(24'h000001, 1'b1, 1'b1, ok);
        #3 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL done_rst_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL done_rst_ready: got %b want 1", in_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        logic [W-1:0] d; logic s; logic [CNT_W-1:0] c;
        send_term(24'h000002, 1'b1, 1'b0, ok);
        send_term(24'h000003, 1'b1, 1'b0, ok);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        send_term(24'h000007, 1'b0, 1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_send: got timeout want accept"); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency_valid: got %b want 1", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL basic_done_ready: got %b want 0", in_ready); end
        get_result(0, d, s, c, ok);
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL basic_bubble_ready: got %b want 1", in_ready); end
        total++; if (d !== 24'h800002)   begin bad++; $display("FAIL basic_data: got %h want 800002", d); end
        total++; if (s !== 1'b0)         begin bad++; $display("FAIL basic_sat: got %b want 0", s); end
        total++; if (c !== 8'd3)         begin bad++; $display("FAIL basic_count: got %0d want 3", c); end
    endtask

    task automatic test_saturation();
        bit ok;
        logic [W-1:0] d; logic s; logic [CNT_W-1:0] c;
        send_term(24'h7FFFF0, 1'b1, 1'b0, ok);
        send_term(24'h000020, 1'b1, 1'b0, ok);
        send_term(24'h000020, 1'b0, 1'b1, ok);
        get_result(1, d, s, c, ok);
        total++; if (d !== 24'h7FFFDF) begin bad++; $display("FAIL sat_data: got %h want 7fffdf", d); end
        total++; if (s !== 1'b1)       begin bad++; $display("FAIL sat_flag: got %b want 1", s); end

        send_term(24'h000020, 1'b0, 1'b0, ok);
        send_term(24'h7FFFF0, 1'b1, 1'b0, ok);
        send_term(24'h000020, 1'b1, 1'b1, ok);
        get_result(0, d, s, c, ok);
        total++; if (d !== 24'h7FFFF0) begin bad++; $display("FAIL sat_order_data: got %h want 7ffff0", d); end
        total++; if (s !== 1'b0)       begin bad++; $display("FAIL sat_order_flag: got %b want 0", s); end

        // Negative-side clamp keeps the sign.
        send_term(24'hFFFFFF, 1'b1, 1'b0, ok);
        send_term(24'h000010, 1'b0, 1'b1, ok);
        get_result(0, d, s, c, ok);
        total++; if (d !== 24'hFFFFFF) begin bad++; $display("FAIL sat_neg_data: got %h want ffffff", d); end
        total++; if (s !== 1'b1)       begin bad++; $display("FAIL sat_neg_flag: got %b want 1", s); end
    endtask

    task automatic test_zero();
        bit ok;
        logic [W-1:0] d; logic s; logic [CNT_W-1:0] c;
        send_term(24'h800000, 1'b0, 1'b1, ok);
        get_result(0, d, s, c, ok);
        total++; if (d !== 24'h000000) begin bad++; $display("FAIL negzero_data: got %h want 000000", d); end
        total++; if (c !== 8'd1)       begin bad++; $display("FAIL negzero_count: got %0d want 1", c); end

        send_term(24'h000005, 1'b1, 1'b0, ok);
        send_term(24'h000005, 1'b0, 1'b1, ok);
        get_result(0, d, s, c, ok);
        total++; if (d !== 24'h000000) begin bad++; $display("FAIL cancel_data: got %h want 000000", d); end

        // First term subtract yields the negated operand.
        send_term(24'h000009, 1'b0, 1'b1, ok);
        get_result(0, d, s, c, ok);
        total++; if (d !== 24'h800009) begin bad++; $display("FAIL first_sub_data: got %h want 800009", d); end
    endtask

    task automatic test_back_pressure();
        bit ok;
        logic [W-1:0] d; logic s; logic [CNT_W-1:0] c;
        int stall_errs;
        send_term(24'h000004, 1'b1, 1'b1, ok);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 24'h000009;
        in_op_add = 1'b1;
        in_last   = 1'b1;
        stall_errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 24'h000004 || out_count !== 8'd1)
                stall_errs++;
        end
        total++; if (stall_errs != 0) begin bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", stall_errs); end
        in_valid = 1'b0;
        get_result(0, d, s, c, ok);
        total++; if (d !== 24'h000004) begin bad++; $display("FAIL bp_data: got %h want 000004", d); end
        total++; if (c !== 8'd1)       begin bad++; $display("FAIL bp_count: got %0d want 1", c); end
        send_term(24'h000006, 1'b1, 1'b1, ok);
        get_result(0, d, s, c, ok);
        total++; if (d !== 24'h000006 || c !== 8'd1) begin
            bad++; $display("FAIL bp_resume: got %h/%0d want 000006/1", d, c);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [W-1:0] d; logic s; logic [CNT_W-1:0] c;
        logic [W-1:0] terms[$];
        bit ops[$];
        for (int p = 0; p < 200; p++) begin
            int len, acc_v, v, cnt;
            bit sat_v;
            len = $urandom_range(1, 20);
            terms.delete(); ops.delete();
            for (int t = 0; t < len; t++) begin
                v = $urandom_range(0, 31) - 16;
                if (v == 0 && $urandom_range(0, 1) == 1) terms.push_back(24'h800000);
                else terms.push_back(int_to_sm(v));
                ops.push_back(1'($urandom_range(0, 1)));
            end
            // Model: signed integers, clamp after every step.
            acc_v = 0; sat_v = 0; cnt = 0;
            for (int t = 0; t < len; t++) begin
                acc_v = ops[t] ? acc_v + sm_to_int(terms[t]) : acc_v - sm_to_int(terms[t]);
                if (acc_v > MAXV)  begin acc_v = MAXV;  sat_v = 1; end
                if (acc_v < -MAXV) begin acc_v = -MAXV; sat_v = 1; end
                if (cnt < 255) cnt++;
            end
            exp_q.push_back(int_to_sm(acc_v));
            exp_sat_q.push_back(sat_v);
            exp_cnt_q.push_back(8'(cnt));
            for (int t = 0; t < len; t++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_data = 24'($urandom);
                    in_last = 1'($urandom);
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
                send_term(terms[t], ops[t], (t == len - 1), ok);
            end
            get_result($urandom_range(0, 3), d, s, c, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand_timeout: pkt %0d got none want result", p); end
            total++; if (d !== exp_q[0])     begin bad++; $display("FAIL rand_data: pkt %0d got %h want %h", p, d, exp_q[0]); end
            total++; if (s !== exp_sat_q[0]) begin bad++; $display("FAIL rand_sat: pkt %0d got %b want %b", p, s, exp_sat_q[0]); end
            total++; if (c !== exp_cnt_q[0]) begin bad++; $display("FAIL rand_count: pkt %0d got %0d want %0d", p, c, exp_cnt_q[0]); end
            void'(exp_q.pop_front());
            void'(exp_sat_q.pop_front());
            void'(exp_cnt_q.pop_front());
        end
    endtask

    task automatic test_long_packet();
        bit ok;
        logic [W-1:0] d; logic s; logic [CNT_W-1:0] c;
        for (int t = 0; t < 300; t++) send_term(24'h000001, 1'b1, (t == 299), ok);
        get_result(0, d, s, c, ok);
        total++; if (c !== 8'd255)     begin bad++; $display("FAIL long_count: got %0d want 255", c); end
        total++; if (d !== 24'h00012C) begin bad++; $display("FAIL long_data: got %h want 00012c", d); end
        total++; if (s !== 1'b0)       begin bad++; $display("FAIL long_sat: got %b want 0", s); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op_add = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_zero();
        test_back_pressure();
        test_random();
        test_long_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
